// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and sizing helpers for the nibble-serial adder.
package nibble_serial_adder_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Number of nibbles in a WIDTH-bit operand.
    function automatic int unsigned nib_count(input int unsigned width);
        return width / NIBBLE_W;
    endfunction

    // Width of the nibble index counter (at least one bit).
    function automatic int unsigned idx_width(input int unsigned width);
        int unsigned n;
        n = nib_count(width);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_add4.sv
// 4-bit combinational ripple-carry adder; c3 is the carry into bit 3.
module nibble_add4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout,
    output logic       c3
);

    logic [4:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[4];
    assign c3   = c[3];

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder computed one nibble per clock through a single 4-bit stage.
// Optional signed overflow output enabled by NIBBLE_SERIAL_ADDER_OVF_EN.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NIB = nib_count(WIDTH);
    localparam int unsigned IW  = idx_width(WIDTH);

    state_t           state;
    state_t           state_n;
    logic [IW-1:0]    idx;
    logic             carry;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_n;
    logic             accept;
    logic             last;

    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [3:0]       s_nib;
    logic             c_out;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    logic             c3;
`else
    logic             c3_unused;
`endif

    assign a_nib = a_q[idx*NIBBLE_W +: NIBBLE_W];
    assign b_nib = b_q[idx*NIBBLE_W +: NIBBLE_W];

    nibble_add4 u_add4 (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry),
        .s    (s_nib),
        .cout (c_out),
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        .c3   (c3)
`else
        .c3   (c3_unused)
`endif
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next state and datapath strobes.
    always_comb begin
        state_n = state;
        accept  = 1'b0;
        last    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                if (idx == IW'(NIB - 1)) begin
                    last    = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Result register with the current nibble merged in.
    always_comb begin
        res_n = res;
        for (int i = 0; i < int'(NIB); i++) begin
            if (idx == IW'(i)) res_n[i*NIBBLE_W +: NIBBLE_W] = s_nib;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx   <= '0;
            carry <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            res   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                a_q   <= a;
                b_q   <= b;
                carry <= cin;
                idx   <= '0;
                busy  <= 1'b1;
            end else if (state == RUN) begin
                res   <= res_n;
                carry <= c_out;
                idx   <= idx + IW'(1);
                if (last) begin
                    idx  <= '0;
                    sum  <= res_n;
                    cout <= c_out;
                    done <= 1'b1;
                    busy <= 1'b0;
                end
            end
        end
    end

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    always_ff @(posedge clk) begin
        if (rst)       ovf <= 1'b0;
        else if (last) ovf <= c3 ^ c_out;
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder: arithmetic reference model plus directed vectors.
module tb_nibble_serial_adder;

    localparam int unsigned W   = 16;
    localparam int unsigned NIB = W / 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int total = 0;
    int bad   = 0;
    bit checking = 1'b0;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an accepted request yields a+b+cin after NIB cycles.
    logic         m_busy, m_done, m_cout, m_ovf;
    logic [W-1:0] m_sum;
    int           m_left;
    logic [W-1:0] p_sum;
    logic         p_cout, p_ovf;

    always @(posedge clk) begin
        logic [W:0] full;
        longint     ss;
        if (rst) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_sum <= '0;
            m_cout <= 1'b0; m_ovf <= 1'b0; m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                if (m_left == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_sum  <= p_sum;
                    m_cout <= p_cout;
                    m_ovf  <= p_ovf;
                end
                m_left <= m_left - 1;
            end else if (start) begin
                full = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
                ss   = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
                m_busy <= 1'b1;
                m_left <= NIB;
                p_sum  <= full[W-1:0];
                p_cout <= full[W];
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
                p_ovf  <= (ss > longint'(2**(W-1) - 1)) || (ss < -longint'(2**(W-1)));
`else
                p_ovf  <= 1'b0;
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            check("busy", 64'(busy), 64'(m_busy));
            check("done", 64'(done), 64'(m_done));
            check("sum",  64'(sum),  64'(m_sum));
            check("cout", 64'(cout), 64'(m_cout));
            check("ovf",  64'(ovf),  64'(m_ovf));
        end
    end

    // One addition with latency and literal result checks.
    task automatic run_add(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                           input logic [W-1:0] es, input logic ec, input logic eo,
                           input string name);
        int cnt;
        @(posedge clk); #1;
        start = 1'b1; a = av; b = bv; cin = cv;
        @(posedge clk); #1;
        start = 1'b0;
        check({name, "_busy_after_accept"}, 64'(busy), 64'd1);
        cnt = 0;
        while (!done && cnt < 20) begin
            check({name, "_busy_running"}, 64'(busy), 64'd1);
            @(posedge clk); #1;
            cnt++;
        end
        check({name, "_latency"}, 64'(cnt), 64'(NIB));
        check({name, "_sum"},  64'(sum),  64'(es));
        check({name, "_cout"}, 64'(cout), 64'(ec));
        check({name, "_ovf"},  64'(ovf),  64'(eo));
        check({name, "_busy_in_done"}, 64'(busy), 64'd0);
    endtask

    logic [W-1:0] tbl_a [6] = '{16'h0001, 16'h8000, 16'h1234, 16'hFFFF, 16'h00F0, 16'h7FFF};
    logic [W-1:0] tbl_b [6] = '{16'h0002, 16'h8000, 16'hEDCB, 16'h0001, 16'h0F0F, 16'h7FFF};

    initial begin
        int ndone;
        int last_done;
        int cyc;
        logic exp_ovf;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_sum",  64'(sum),  64'd0);
        check("reset_cout", 64'(cout), 64'd0);
        check("reset_ovf",  64'(ovf),  64'd0);
        rst = 1'b0;
        checking = 1'b1;

        run_add(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, "inc_byte");
        run_add(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, "ripple_all");
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        exp_ovf = 1'b1;
`else
        exp_ovf = 1'b0;
`endif
        run_add(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, exp_ovf, "signed_ovf");

        // Start during a run must be ignored.
        @(posedge clk); #1;
        start = 1'b1; a = 16'h1234; b = 16'h1111; cin = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; a = 16'hFFFF;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) begin
                ndone++;
                check("midstart_sum", 64'(sum), 64'h2345);
            end
            @(posedge clk); #1;
        end
        check("midstart_done_count", 64'(ndone), 64'd1);

        // Reset two cycles into a run aborts without a done pulse.
        start = 1'b1; a = 16'h5555; b = 16'h1111;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_sum",  64'(sum),  64'd0);
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) ndone++;
            @(posedge clk); #1;
        end
        check("abort_no_done", 64'(ndone), 64'd0);
        run_add(16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, "after_abort");

        // Start held high: back-to-back additions every NIB+1 cycles.
        ndone = 0;
        last_done = -1;
        start = 1'b1;
        for (cyc = 0; cyc < 30; cyc++) begin
            a   = tbl_a[cyc % 6];
            b   = tbl_b[cyc % 6];
            cin = 1'(cyc % 2);
            @(posedge clk); #1;
            if (done) begin
                if (last_done >= 0)
                    check("b2b_interval", 64'(cyc - last_done), 64'(NIB + 1));
                last_done = cyc;
                ndone++;
            end
        end
        start = 1'b0;
        repeat (NIB + 2) @(posedge clk);
        #1;
        check("b2b_done_count", 64'(ndone >= 5), 64'd1);

        checking = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
